// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order allocation, multi-port write-back, up to two commits
// per cycle, bypassed operand lookup and a mispredict flush handshake with the LSB.
module rob_multi_commit #(
    parameter int DEPTH    = 16,
    parameter int IDW      = 4,
    parameter int WB_PORTS = 2,
    parameter int CMT_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     alloc_valid,
    input  logic [2:0]               alloc_type,
    input  logic [4:0]               alloc_rd,
    input  logic [31:0]              alloc_prd_pc,
    output logic                     alloc_ready,
    output logic [IDW-1:0]           alloc_id,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*IDW-1:0]  wb_id,
    input  logic [WB_PORTS*32-1:0]   wb_val,
    input  logic [WB_PORTS*32-1:0]   wb_rel_pc,
    input  logic                     st_rdy_valid,
    input  logic [IDW-1:0]           st_rdy_id,
    input  logic [IDW-1:0]           q_id1,
    input  logic [IDW-1:0]           q_id2,
    output logic                     q_rdy1,
    output logic                     q_rdy2,
    output logic [31:0]              q_val1,
    output logic [31:0]              q_val2,
    output logic [CMT_W-1:0]         cmt_rf_valid,
    output logic [CMT_W*5-1:0]       cmt_rf_rd,
    output logic [CMT_W*32-1:0]      cmt_rf_val,
    output logic [CMT_W*IDW-1:0]     cmt_rf_id,
    output logic                     cmt_st_valid,
    output logic [IDW-1:0]           cmt_st_id,
    output logic                     flush_req,
    output logic [31:0]              flush_pc,
    output logic                     flush_busy,
    input  logic                     lsb_clear_done,
    output logic [IDW-1:0]           head_id,
    output logic [IDW:0]             count
);

    localparam logic [2:0] T_ALU = 3'd0;
    localparam logic [2:0] T_BR  = 3'd1;
    localparam logic [2:0] T_JMP = 3'd2;
    localparam logic [2:0] T_LD  = 3'd3;
    localparam logic [2:0] T_ST  = 3'd4;
    localparam logic [IDW:0] FULL = (IDW+1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state;
    logic [IDW-1:0]     head, tail;
    logic [DEPTH-1:0]   busy, ready;
    logic [2:0]         typ    [DEPTH];
    logic [4:0]         rd     [DEPTH];
    logic [31:0]        prd_pc [DEPTH];
    logic [31:0]        val    [DEPTH];
    logic [31:0]        rel_pc [DEPTH];

    logic               alloc_fire;
    logic [IDW-1:0]     h1;
    logic [2:0]         ty0, ty1;
    logic               c0, c1, mis;
    logic [IDW:0]       n_cmt;
    logic [1:0]         rfv_n;
    logic [9:0]         rd_n;
    logic [63:0]        val_n;
    logic [2*IDW-1:0]   id_n;
    logic               stv_n;
    logic [IDW-1:0]     sti_n;
    logic [IDW-1:0]     qid [2];
    logic [1:0]         qr;
    logic [1:0][31:0]   qv;

    assign alloc_ready = (count != FULL) && (state == RUN);
    assign alloc_fire  = rdy && alloc_valid && alloc_ready;
    assign alloc_id    = tail;
    assign head_id     = head;
    assign flush_busy  = (state == FLUSH);

    // Slot 1 only retires behind a cleanly retiring slot 0 and never a branch or a second store.
    always_comb begin
        h1  = head + 1'b1;
        ty0 = typ[head];
        ty1 = typ[h1];
        c0  = (state == RUN) && busy[head] && ready[head];
        mis = c0 && (ty0 == T_BR || ty0 == T_JMP) && (prd_pc[head] != rel_pc[head]);
        c1  = (CMT_W == 2) && c0 && !mis && busy[h1] && ready[h1] &&
              (ty1 != T_BR) && (ty1 != T_JMP) && !(ty0 == T_ST && ty1 == T_ST);
        n_cmt = '0;
        if (c0 && !mis)
            n_cmt = c1 ? (IDW+1)'(2) : (IDW+1)'(1);
        rfv_n[0] = c0 && (ty0 == T_ALU || ty0 == T_LD || ty0 == T_JMP);
        rfv_n[1] = c1 && (ty1 == T_ALU || ty1 == T_LD);
        stv_n = 1'b0;
        sti_n = head;
        if (c0 && !mis && ty0 == T_ST) begin
            stv_n = 1'b1;
        end else if (c1 && ty1 == T_ST) begin
            stv_n = 1'b1;
            sti_n = h1;
        end
        rd_n  = {rd[h1], rd[head]};
        val_n = {val[h1], val[head]};
        id_n  = {h1, head};
    end

    assign qid[0] = q_id1;
    assign qid[1] = q_id2;

    // A result arriving on a write-back bus this cycle is forwarded ahead of the stored copy.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            qr[k] = busy[qid[k]] && ready[qid[k]];
            qv[k] = val[qid[k]];
            if (state == RUN && busy[qid[k]]) begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && wb_id[p*IDW +: IDW] == qid[k]) begin
                        qr[k] = 1'b1;
                        qv[k] = wb_val[p*32 +: 32];
                    end
                end
            end
        end
    end

    assign q_rdy1 = qr[0];
    assign q_rdy2 = qr[1];
    assign q_val1 = qv[0];
    assign q_val2 = qv[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            cmt_rf_valid <= '0;
            cmt_rf_rd    <= '0;
            cmt_rf_val   <= '0;
            cmt_rf_id    <= '0;
            cmt_st_valid <= 1'b0;
            cmt_st_id    <= '0;
            flush_req    <= 1'b0;
            flush_pc     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                typ[i]    <= '0;
                rd[i]     <= '0;
                prd_pc[i] <= '0;
                val[i]    <= '0;
                rel_pc[i] <= '0;
            end
        end else if (rdy) begin
            cmt_rf_valid <= '0;
            cmt_st_valid <= 1'b0;
            flush_req    <= 1'b0;
            case (state)
                RUN: begin
                    for (int p = 0; p < WB_PORTS; p++) begin
                        if (wb_valid[p] && busy[wb_id[p*IDW +: IDW]]) begin
                            val[wb_id[p*IDW +: IDW]]    <= wb_val[p*32 +: 32];
                            rel_pc[wb_id[p*IDW +: IDW]] <= wb_rel_pc[p*32 +: 32];
                            ready[wb_id[p*IDW +: IDW]]  <= 1'b1;
                        end
                    end
                    if (st_rdy_valid && busy[st_rdy_id])
                        ready[st_rdy_id] <= 1'b1;

                    cmt_rf_valid <= rfv_n[CMT_W-1:0];
                    cmt_rf_rd    <= rd_n[CMT_W*5-1:0];
                    cmt_rf_val   <= val_n[CMT_W*32-1:0];
                    cmt_rf_id    <= id_n[CMT_W*IDW-1:0];
                    cmt_st_valid <= stv_n;
                    cmt_st_id    <= sti_n;
                    if (c0 && !mis) begin
                        busy[head]  <= 1'b0;
                        ready[head] <= 1'b0;
                    end
                    if (c1) begin
                        busy[h1]  <= 1'b0;
                        ready[h1] <= 1'b0;
                    end
                    if (mis) begin
                        flush_req <= 1'b1;
                        flush_pc  <= rel_pc[head];
                        state     <= FLUSH;
                    end
                    head <= head + n_cmt[IDW-1:0];

                    if (alloc_fire) begin
                        busy[tail]   <= 1'b1;
                        ready[tail]  <= 1'b0;
                        typ[tail]    <= alloc_type;
                        rd[tail]     <= alloc_rd;
                        prd_pc[tail] <= alloc_prd_pc;
                        tail         <= tail + 1'b1;
                    end
                    count <= count + {{IDW{1'b0}}, alloc_fire} - n_cmt;
                end
                FLUSH: begin
                    // Everything younger than the mispredicted entry is discarded once the LSB agrees.
                    if (lsb_clear_done) begin
                        busy  <= '0;
                        ready <= '0;
                        head  <= head + 1'b1;
                        tail  <= head + 1'b1;
                        count <= '0;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: fill, dual commit, store pairing, bypass,
// mispredict flush, wrap-around traffic and reset during a flush.
module tb_rob_multi_commit;

    localparam int IDW = 4;
    localparam logic [2:0] T_ALU = 3'd0;
    localparam logic [2:0] T_BR  = 3'd1;
    localparam logic [2:0] T_JMP = 3'd2;
    localparam logic [2:0] T_ST  = 3'd4;

    logic            clk, rst_n, rdy;
    logic            alloc_valid;
    logic [2:0]      alloc_type;
    logic [4:0]      alloc_rd;
    logic [31:0]     alloc_prd_pc;
    logic            alloc_ready;
    logic [IDW-1:0]  alloc_id;
    logic [1:0]      wb_valid;
    logic [2*IDW-1:0] wb_id;
    logic [63:0]     wb_val, wb_rel_pc;
    logic            st_rdy_valid;
    logic [IDW-1:0]  st_rdy_id, q_id1, q_id2;
    logic            q_rdy1, q_rdy2;
    logic [31:0]     q_val1, q_val2;
    logic [1:0]      cmt_rf_valid;
    logic [9:0]      cmt_rf_rd;
    logic [63:0]     cmt_rf_val;
    logic [2*IDW-1:0] cmt_rf_id;
    logic            cmt_st_valid;
    logic [IDW-1:0]  cmt_st_id;
    logic            flush_req, flush_busy, lsb_clear_done;
    logic [31:0]     flush_pc;
    logic [IDW-1:0]  head_id;
    logic [IDW:0]    count;

    int total = 0;
    int bad = 0;

    rob_multi_commit #(.DEPTH(16), .IDW(IDW), .WB_PORTS(2), .CMT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_prd_pc(alloc_prd_pc), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .wb_rel_pc(wb_rel_pc),
        .st_rdy_valid(st_rdy_valid), .st_rdy_id(st_rdy_id),
        .q_id1(q_id1), .q_id2(q_id2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2),
        .q_val1(q_val1), .q_val2(q_val2),
        .cmt_rf_valid(cmt_rf_valid), .cmt_rf_rd(cmt_rf_rd), .cmt_rf_val(cmt_rf_val),
        .cmt_rf_id(cmt_rf_id), .cmt_st_valid(cmt_st_valid), .cmt_st_id(cmt_st_id),
        .flush_req(flush_req), .flush_pc(flush_pc), .flush_busy(flush_busy),
        .lsb_clear_done(lsb_clear_done), .head_id(head_id), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task drive_idle;
        alloc_valid = 0; alloc_type = T_ALU; alloc_rd = 0; alloc_prd_pc = 0;
        wb_valid = 0; wb_id = 0; wb_val = 0; wb_rel_pc = 0;
        st_rdy_valid = 0; st_rdy_id = 0; q_id1 = 0; q_id2 = 0; lsb_clear_done = 0;
    endtask

    task test_reset;
        rst_n = 0; rdy = 1; drive_idle();
        #12;
        total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_alloc_ready got=%b want=1", alloc_ready); end
        total++; if (alloc_id !== 4'd0 || head_id !== 4'd0) begin bad++; $display("[TB] FAIL reset_ptrs got=%0d/%0d want=0/0", alloc_id, head_id); end
        total++; if (cmt_rf_valid !== 2'b00 || cmt_st_valid !== 1'b0 || flush_req !== 1'b0 || flush_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%b%b%b%b want=0000", cmt_rf_valid, cmt_st_valid, flush_req, flush_busy); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task test_fill;
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1; alloc_type = T_ALU; alloc_rd = 5'(i + 1); alloc_prd_pc = 0;
            total++; if (alloc_id !== 4'(i) || alloc_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL fill_alloc_id got=%0d rdy=%b want=%0d rdy=1", alloc_id, alloc_ready, i); end
            tick();
        end
        total++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL fill_full got=%0d rdy=%b want=16 rdy=0", count, alloc_ready); end
        tick();
        alloc_valid = 0;
        total++; if (count !== 5'd16 || alloc_id !== 4'd0) begin
            bad++; $display("[TB] FAIL fill_refused got=%0d id=%0d want=16 id=0", count, alloc_id); end
    endtask

    task test_dual_commit;
        wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'd7, 32'd5}; wb_rel_pc = 0;
        tick();
        wb_valid = 0;
        total++; if (cmt_rf_valid !== 2'b00) begin bad++; $display("[TB] FAIL dual_early got=%b want=00", cmt_rf_valid); end
        alloc_valid = 1; alloc_type = T_ALU; alloc_rd = 5'd30;
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL dual_full_ready got=%b want=0", alloc_ready); end
        tick();
        alloc_valid = 0;
        total++; if (cmt_rf_valid !== 2'b11 || cmt_rf_id !== {4'd1, 4'd0}) begin
            bad++; $display("[TB] FAIL dual_commit got=%b ids=%h want=11 ids=10", cmt_rf_valid, cmt_rf_id); end
        total++; if (cmt_rf_val !== {32'd7, 32'd5} || cmt_rf_rd !== {5'd2, 5'd1}) begin
            bad++; $display("[TB] FAIL dual_data got=%h rd=%h want=0000000700000005 rd=041", cmt_rf_val, cmt_rf_rd); end
        total++; if (count !== 5'd14 || alloc_id !== 4'd0 || head_id !== 4'd2) begin
            bad++; $display("[TB] FAIL dual_count got=%0d tail=%0d head=%0d want=14/0/2", count, alloc_id, head_id); end
        tick();
        total++; if (cmt_rf_valid !== 2'b00) begin bad++; $display("[TB] FAIL dual_pulse got=%b want=00", cmt_rf_valid); end
    endtask

    task test_drain;
        int perm[14];
        int idx, next_tag, cyc, tmp, j;
        logic [31:0] ev;
        for (int i = 0; i < 14; i++) perm[i] = i + 2;
        for (int i = 13; i > 0; i--) begin
            j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        idx = 0; next_tag = 2; cyc = 0;
        while (next_tag < 16 && cyc < 80) begin
            for (int s = 0; s < 2; s++) begin
                if (cmt_rf_valid[s]) begin
                    ev = 32'(next_tag + 100);
                    total++; if (cmt_rf_id[s*IDW +: IDW] !== 4'(next_tag) || cmt_rf_val[s*32 +: 32] !== ev || cmt_rf_rd[s*5 +: 5] !== 5'(next_tag + 1)) begin
                        bad++; $display("[TB] FAIL drain_order got=%0d val=%0d want=%0d val=%0d", cmt_rf_id[s*IDW +: IDW], cmt_rf_val[s*32 +: 32], next_tag, ev); end
                    next_tag++;
                end
            end
            wb_valid = 0;
            for (int p = 0; p < 2; p++) begin
                if (idx < 14) begin
                    wb_valid[p] = 1; wb_id[p*IDW +: IDW] = 4'(perm[idx]); wb_val[p*32 +: 32] = 32'(perm[idx] + 100);
                    idx++;
                end
            end
            tick();
            cyc++;
        end
        wb_valid = 0;
        total++; if (next_tag !== 16) begin bad++; $display("[TB] FAIL drain_timeout got=%0d want=16", next_tag); end
        total++; if (count !== 5'd0 || head_id !== 4'd0) begin
            bad++; $display("[TB] FAIL drain_empty got=%0d head=%0d want=0/0", count, head_id); end
    endtask

    task test_store_pair;
        alloc_valid = 1; alloc_type = T_ST; alloc_rd = 0; tick();
        alloc_valid = 1; alloc_type = T_ST; tick();
        alloc_valid = 0; st_rdy_valid = 1; st_rdy_id = 4'd1; tick();
        st_rdy_id = 4'd0; tick();
        st_rdy_valid = 0;
        total++; if (cmt_st_valid !== 1'b0) begin bad++; $display("[TB] FAIL st_early got=%b want=0", cmt_st_valid); end
        tick();
        total++; if (cmt_st_valid !== 1'b1 || cmt_st_id !== 4'd0 || cmt_rf_valid !== 2'b00) begin
            bad++; $display("[TB] FAIL st_first got=%b id=%0d rf=%b want=1 id=0 rf=00", cmt_st_valid, cmt_st_id, cmt_rf_valid); end
        total++; if (count !== 5'd1 || head_id !== 4'd1) begin bad++; $display("[TB] FAIL st_first_count got=%0d head=%0d want=1/1", count, head_id); end
        tick();
        total++; if (cmt_st_valid !== 1'b1 || cmt_st_id !== 4'd1) begin
            bad++; $display("[TB] FAIL st_second got=%b id=%0d want=1 id=1", cmt_st_valid, cmt_st_id); end
        tick();
        total++; if (cmt_st_valid !== 1'b0 || count !== 5'd0 || head_id !== 4'd2) begin
            bad++; $display("[TB] FAIL st_done got=%b cnt=%0d head=%0d want=0/0/2", cmt_st_valid, count, head_id); end
    endtask

    task test_bypass_branch;
        alloc_valid = 1; alloc_type = T_BR; alloc_rd = 0; alloc_prd_pc = 32'h40; tick();
        alloc_type = T_ALU; alloc_rd = 5'd9; alloc_prd_pc = 0; tick();
        alloc_valid = 0;
        wb_valid = 2'b11; wb_id = {4'd3, 4'd3}; wb_val = {32'hAB, 32'h99}; wb_rel_pc = 0;
        q_id1 = 4'd3; q_id2 = 4'd2;
        #1;
        total++; if (q_rdy1 !== 1'b1 || q_val1 !== 32'hAB) begin
            bad++; $display("[TB] FAIL query_bypass got=%b val=%h want=1 val=ab", q_rdy1, q_val1); end
        total++; if (q_rdy2 !== 1'b0) begin bad++; $display("[TB] FAIL query_not_ready got=%b want=0", q_rdy2); end
        tick();
        wb_valid = 2'b01; wb_id = {4'd0, 4'd2}; wb_val = {32'd0, 32'h11}; wb_rel_pc = {32'd0, 32'h40};
        #1;
        total++; if (q_rdy1 !== 1'b1 || q_val1 !== 32'hAB) begin
            bad++; $display("[TB] FAIL query_stored got=%b val=%h want=1 val=ab", q_rdy1, q_val1); end
        total++; if (q_rdy2 !== 1'b1 || q_val2 !== 32'h11) begin
            bad++; $display("[TB] FAIL query_bypass2 got=%b val=%h want=1 val=11", q_rdy2, q_val2); end
        tick();
        wb_valid = 0;
        total++; if (cmt_rf_valid !== 2'b00) begin bad++; $display("[TB] FAIL br_early got=%b want=00", cmt_rf_valid); end
        tick();
        total++; if (cmt_rf_valid !== 2'b10 || cmt_rf_id[7:4] !== 4'd3 || cmt_rf_rd[9:5] !== 5'd9 || cmt_rf_val[63:32] !== 32'hAB) begin
            bad++; $display("[TB] FAIL br_pair got=%b id=%0d rd=%0d val=%h want=10 id=3 rd=9 val=ab", cmt_rf_valid, cmt_rf_id[7:4], cmt_rf_rd[9:5], cmt_rf_val[63:32]); end
        total++; if (flush_req !== 1'b0 || count !== 5'd0 || head_id !== 4'd4) begin
            bad++; $display("[TB] FAIL br_state got=%b cnt=%0d head=%0d want=0/0/4", flush_req, count, head_id); end
    endtask

    task test_jmp_flush;
        alloc_valid = 1; alloc_type = T_JMP; alloc_rd = 5'd1; alloc_prd_pc = 32'h100; tick();
        alloc_type = T_ALU; alloc_rd = 5'd2; alloc_prd_pc = 0; tick();
        alloc_valid = 0; lsb_clear_done = 1;
        wb_valid = 2'b11; wb_id = {4'd5, 4'd4}; wb_val = {32'h66, 32'h55}; wb_rel_pc = {32'd0, 32'h200};
        tick();
        lsb_clear_done = 0; wb_valid = 0;
        total++; if (count !== 5'd2 || flush_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL clear_done_in_run got=%0d busy=%b want=2 busy=0", count, flush_busy); end
        tick();
        total++; if (cmt_rf_valid !== 2'b01 || cmt_rf_rd[4:0] !== 5'd1 || cmt_rf_id[3:0] !== 4'd4 || cmt_rf_val[31:0] !== 32'h55) begin
            bad++; $display("[TB] FAIL jmp_commit got=%b rd=%0d id=%0d val=%h want=01 rd=1 id=4 val=55", cmt_rf_valid, cmt_rf_rd[4:0], cmt_rf_id[3:0], cmt_rf_val[31:0]); end
        total++; if (flush_req !== 1'b1 || flush_pc !== 32'h200 || flush_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL jmp_flush got=%b pc=%h busy=%b want=1 pc=200 busy=1", flush_req, flush_pc, flush_busy); end
        total++; if (alloc_ready !== 1'b0 || count !== 5'd2 || head_id !== 4'd4) begin
            bad++; $display("[TB] FAIL jmp_hold got=%b cnt=%0d head=%0d want=0/2/4", alloc_ready, count, head_id); end
        alloc_valid = 1; alloc_type = T_ALU; wb_valid = 2'b01; wb_id = {4'd0, 4'd5}; wb_val = 0;
        tick();
        total++; if (flush_req !== 1'b0 || cmt_rf_valid !== 2'b00 || flush_busy !== 1'b1 || alloc_id !== 4'd6) begin
            bad++; $display("[TB] FAIL flush_wait got=%b%b busy=%b tail=%0d want=000 busy=1 tail=6", flush_req, cmt_rf_valid, flush_busy, alloc_id); end
        tick();
        alloc_valid = 0; wb_valid = 0; lsb_clear_done = 1;
        tick();
        lsb_clear_done = 0;
        total++; if (flush_busy !== 1'b0 || count !== 5'd0 || alloc_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL flush_done got=%b cnt=%0d rdy=%b want=0/0/1", flush_busy, count, alloc_ready); end
        total++; if (alloc_id !== 4'd5 || head_id !== 4'd5 || cmt_rf_valid !== 2'b00) begin
            bad++; $display("[TB] FAIL flush_ptrs got=%0d/%0d rf=%b want=5/5 rf=00", alloc_id, head_id, cmt_rf_valid); end
    endtask

    task test_wrap;
        logic [IDW-1:0] pend[$];
        logic [IDW-1:0] exp_tag[$];
        logic [31:0]    exp_val[$];
        logic [31:0]    tag_val[16];
        logic [IDW-1:0] mtail, new_tag, t;
        int n_alloc, n_cmt, cyc, idx;
        logic have_new;
        mtail = 4'd5; n_alloc = 0; n_cmt = 0; cyc = 0;
        while (n_cmt < 40 && cyc < 600) begin
            for (int s = 0; s < 2; s++) begin
                if (cmt_rf_valid[s]) begin
                    total++;
                    if (exp_tag.size() == 0) begin
                        bad++; $display("[TB] FAIL wrap_extra got=%0d want=none", cmt_rf_id[s*IDW +: IDW]);
                    end else begin
                        if (cmt_rf_id[s*IDW +: IDW] !== exp_tag[0] || cmt_rf_val[s*32 +: 32] !== exp_val[0]) begin
                            bad++; $display("[TB] FAIL wrap_order got=%0d val=%h want=%0d val=%h", cmt_rf_id[s*IDW +: IDW], cmt_rf_val[s*32 +: 32], exp_tag[0], exp_val[0]); end
                        void'(exp_tag.pop_front());
                        void'(exp_val.pop_front());
                    end
                    n_cmt++;
                end
            end
            wb_valid = 0;
            for (int p = 0; p < 2; p++) begin
                if (pend.size() > 0) begin
                    idx = $urandom_range(0, pend.size() - 1);
                    t = pend[idx];
                    pend.delete(idx);
                    wb_valid[p] = 1; wb_id[p*IDW +: IDW] = t; wb_val[p*32 +: 32] = tag_val[t];
                end
            end
            alloc_valid = 0; have_new = 0; new_tag = 0;
            if (n_alloc < 40 && alloc_ready) begin
                alloc_valid = 1; alloc_type = T_ALU; alloc_rd = 5'(n_alloc % 31 + 1);
                total++; if (alloc_id !== mtail) begin
                    bad++; $display("[TB] FAIL wrap_alloc_id got=%0d want=%0d", alloc_id, mtail); end
                tag_val[mtail] = 32'h1000 + 32'(n_alloc);
                exp_tag.push_back(mtail);
                exp_val.push_back(32'h1000 + 32'(n_alloc));
                have_new = 1; new_tag = mtail;
                mtail = mtail + 1'b1;
                n_alloc++;
            end
            tick();
            cyc++;
            if (have_new) pend.push_back(new_tag);
        end
        alloc_valid = 0; wb_valid = 0;
        total++; if (n_cmt !== 40) begin bad++; $display("[TB] FAIL wrap_timeout got=%0d want=40", n_cmt); end
        total++; if (count !== 5'd0 || head_id !== 4'd13) begin
            bad++; $display("[TB] FAIL wrap_end got=%0d head=%0d want=0/13", count, head_id); end
    endtask

    task test_reset_mid_flush;
        alloc_valid = 1; alloc_type = T_BR; alloc_rd = 0; alloc_prd_pc = 0; tick();
        alloc_valid = 0;
        wb_valid = 2'b01; wb_id = {4'd0, 4'd13}; wb_val = 0; wb_rel_pc = {32'd0, 32'h44}; tick();
        wb_valid = 0; tick();
        total++; if (flush_req !== 1'b1 || flush_pc !== 32'h44) begin
            bad++; $display("[TB] FAIL br_mispredict got=%b pc=%h want=1 pc=44", flush_req, flush_pc); end
        #2; rst_n = 0; #1;
        total++; if (flush_req !== 1'b0 || flush_busy !== 1'b0 || count !== 5'd0 || head_id !== 4'd0 || alloc_id !== 4'd0) begin
            bad++; $display("[TB] FAIL reset_mid_flush got=%b%b cnt=%0d h=%0d t=%0d want=00 0/0/0", flush_req, flush_busy, count, head_id, alloc_id); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_dual_commit();
        test_drain();
        test_store_pair();
        test_bypass_branch();
        test_jmp_flush();
        test_wrap();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
